bf16_result_drain: RTL and testbench
====================================

# bf16_result_drain

Downstream output stage of the bfloat16 multiply-accumulate datapath. It accepts finished float32 accumulator results over a valid/ready stream and rounds each to bfloat16 (round-to-nearest-even). It buffers the rounded words in a small FIFO and presents them with flags to the network-side consumer. It decouples MAC drain timing from consumer backpressure.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  in_data/in_last valid
- in_ready  out  1  stage can accept this cycle
- in_data  in  32  float32 accumulator result
- in_last  in  1  marks final result of a tile
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  16  rounded bfloat16
- out_last  out  1  in_last carried with the word
- out_flags  out  2  {overflow, inexact} for the head word
- level  out  $clog2(DEPTH)+1  FIFO occupancy, excludes the convert register

## Operation
- Accept on in_valid && in_ready. Pop on out_valid && out_ready.
- Two-place pipeline:
  - convert register (stage_valid, data, last)
  - FIFO of {bf16, last, flags}
- Rounding happens combinationally between the convert register and the FIFO write port.
- Fields: s=in[31], e=in[30:23], m=in[22:0].
- Class handling:
  - NaN (e=FF, m≠0): out {s,8'hFF,7'h40}, flags 0.
  - Inf (e=FF, m=0): out {s,8'hFF,7'h00}, flags 0.
  - Zero/subnormal (e=0): flush to {s,15'h0}. inexact=|m.
  - Normal: lsb=in[16], rnd=in[15], sticky=|in[14:0]. out=in[31:16]+(rnd&&(sticky||lsb)), 16-bit add with carry rippling into exponent. inexact=rnd||sticky. overflow=1 when a finite input rounds to exponent FF; the result is then signed infinity.
- FIFO write when stage_valid && (!full || pop). Convert register loads on accept, clears when written to FIFO without a simultaneous accept.
- in_ready = !stage_valid || !full, with full being registered state. in_ready never depends on out_ready combinationally.
- Ordering: strict FIFO. out_last and out_flags are always those of the word on out_data.

## Timing
- Latency: accept at edge N → FIFO write at edge N+1 → out_valid high after edge N+1 (2 cycles), when the FIFO was empty.
- Throughput: 1 word/cycle while the consumer drains at 1/cycle.
- Capacity: DEPTH+1 words (FIFO plus convert register) before in_ready falls.
- Full FIFO with simultaneous pop and write: both occur, level unchanged.
- Empty FIFO with simultaneous write: the word is not visible until the next cycle; no fall-through.
- Pointers wrap modulo DEPTH. level uses an extra bit to distinguish full from empty.
- out_data/out_last/out_flags hold steady while out_valid && !out_ready.
- Reset values:
  - in_ready=1
  - out_valid=0
  - out_data=0
  - out_last=0
  - out_flags=0
  - level=0
  - stage_valid=0, pointers=0
- Reset mid-stream discards all buffered words; no partial tile is emitted after release.

## Structure
- Shared package nnoc_fp_pkg:
  - fp32_t/bf16_t packed structs (sign, exp, mant)
  - constants BF16_QNAN=16'h7FC0, FP32_EXP_MAX=8'hFF, BF16_MANT_W=7
  - function fp32_to_bf16_rne returning {bf16, overflow, inexact}
- One sub-module: sync_fifo (parameterized width/depth, registered full/empty, level output), instantiated with width 19.

## Test plan
- Basic: in_data 32'h3F80_0000, out_ready=1 → out_data 16'h3F80, flags 00, out_valid exactly 2 cycles after accept.
- RNE ties:
  - 32'h3F80_8000 → 16'h3F80, flags 01.
  - 32'h3F81_8000 → 16'h3F82, flags 01.
  - 32'h3F80_8001 → 16'h3F81, flags 01.
- Overflow/specials:
  - 32'h7F7F_FFFF → 16'h7F80, flags 11.
  - 32'hFF80_0000 → 16'hFF80, flags 00.
  - 32'h7F80_0001 → 16'h7FC0, flags 00.
- Subnormal flush:
  - 32'h0000_1234 → 16'h0000, flags 01.
  - 32'h8000_0000 → 16'h8000, flags 00.
- Backpressure: DEPTH=4, out_ready=0, stream 8 words.
  - in_ready falls after 5 accepts; level=4.
  - Raise out_ready: 8 words emerge in order, no gaps once streaming, in_last on word 8 only.
- Reset mid-stream: 3 words buffered, rst_n low for 1 cycle → out_valid=0, level=0, in_ready=1. The next accepted word emerges alone after 2 cycles.

Source files
------------

// File: rtl/nnoc_fp_pkg.sv
// Shared floating-point types and the float32 -> bfloat16 round-to-nearest-even helper.
package nnoc_fp_pkg;
    localparam logic [15:0] BF16_QNAN    = 16'h7FC0;
    localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
    localparam int          BF16_MANT_W  = 7;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    typedef struct packed {
        logic                   sign;
        logic [7:0]             exp;
        logic [BF16_MANT_W-1:0] mant;
    } bf16_t;

    // Returns {bf16, overflow, inexact}.
    function automatic logic [17:0] fp32_to_bf16_rne(input fp32_t x);
        bf16_t r;
        logic  ovf, inx, lsb, rnd, sticky;
        r   = {x.sign, x.exp, x.mant[22:16]};
        ovf = 1'b0;
        inx = 1'b0;
        lsb = x.mant[16];
        rnd = x.mant[15];
        sticky = |x.mant[14:0];
        if (x.exp == FP32_EXP_MAX) begin
            r = (x.mant != '0) ? {x.sign, BF16_QNAN[14:0]} : {x.sign, FP32_EXP_MAX, 7'h00};
        end else if (x.exp == 8'h00) begin
            r   = {x.sign, 15'h0000};
            inx = |x.mant;
        end else begin
            // Carry out of the mantissa ripples into the exponent; FE->FF yields signed infinity.
            r   = r + {15'h0000, rnd & (sticky | lsb)};
            ovf = (r.exp == FP32_EXP_MAX);
            inx = rnd | sticky;
        end
        return {r, ovf, inx};
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty and an occupancy count; no fall-through.
module sync_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      level_nxt;

    assign rd_data   = mem[rd_ptr];
    assign level_nxt = level + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};

    // Storage is reset so the head reads as zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            full  <= (level_nxt == (AW+1)'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end
endmodule

// File: rtl/bf16_result_drain.sv
// Accumulator result drain: convert register, RNE rounding to bf16, then a FIFO toward the consumer.
module bf16_result_drain
    import nnoc_fp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_data,
    output logic                   out_last,
    output logic [1:0]             out_flags,
    output logic [$clog2(DEPTH):0] level
);
    logic        stage_valid, stage_last;
    fp32_t       stage_data;
    logic        full, empty, accept, pop, wr;
    logic [17:0] conv;
    logic [18:0] rd_data;

    // in_ready only looks at registered state, never at out_ready.
    assign in_ready  = !stage_valid || !full;
    assign accept    = in_valid && in_ready;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign wr        = stage_valid && (!full || pop);
    assign conv      = fp32_to_bf16_rne(stage_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_data  <= '0;
            stage_last  <= 1'b0;
        end else if (accept) begin
            stage_valid <= 1'b1;
            stage_data  <= in_data;
            stage_last  <= in_last;
        end else if (wr) begin
            stage_valid <= 1'b0;
        end
    end

    sync_fifo #(.WIDTH(19), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr),
        .wr_data ({conv[17:2], stage_last, conv[1:0]}),
        .rd_en   (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign out_data  = rd_data[18:3];
    assign out_last  = rd_data[2];
    assign out_flags = rd_data[1:0];
endmodule

// File: tb/tb_bf16_result_drain.sv
// Self-checking bench: directed rounding vectors, backpressure, mid-stream reset and a randomized scoreboard run.
module tb_bf16_result_drain;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last;
    logic [31:0] in_data;
    logic        out_valid, out_ready, out_last;
    logic [15:0] out_data;
    logic [1:0]  out_flags;
    logic [2:0]  level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] d;
        logic        l;
        logic [1:0]  f;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    bf16_result_drain #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_flags(out_flags), .level(level)
    );

    // Reference: treat the magnitude as an integer, split into kept/dropped parts, round half to even.
    function automatic exp_t model(input logic [31:0] x, input logic last);
        exp_t r;
        int unsigned e, m, mag, keep, drop;
        logic up;
        e = x[30:23];
        m = x[22:0];
        r.l = last;
        r.f = 2'b00;
        if (e == 255) begin
            r.d = (m != 0) ? {x[31], 15'h7FC0} : {x[31], 15'h7F80};
        end else if (e == 0) begin
            r.d = {x[31], 15'h0000};
            r.f = {1'b0, m != 0};
        end else begin
            mag  = x[30:0];
            keep = mag / 65536;
            drop = mag % 65536;
            up   = (drop > 32768) || (drop == 32768 && (keep % 2) == 1);
            keep = keep + (up ? 1 : 0);
            r.f  = {keep >= 32'h7F80, drop != 0};
            r.d  = {x[31], keep[14:0]};
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 4))
            1: w[15:0] = 16'h8000;
            2: w[30:16] = 15'h7F7F;
            3: w[30:23] = 8'h00;
            4: w[30:23] = 8'hFF;
            default: ;
        endcase
        return w;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
        checks++; if (out_last !== 1'b0 || out_flags !== 2'b00) begin errors++; $display("FAIL reset_last_flags got %b/%b want 0/00", out_last, out_flags); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h3F80_0000; in_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early got out_valid=%b want 0", out_valid); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got out_valid=%b want 1", out_valid); end
        checks++; if (out_data !== 16'h3F80 || out_flags !== 2'b00) begin errors++; $display("FAIL basic_data got %h/%b want 3f80/00", out_data, out_flags); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_vectors();
        logic [31:0] vin [9];
        logic [15:0] vd  [9];
        logic [1:0]  vf  [9];
        int wait_n;
        vin = '{32'h3F80_8000, 32'h3F81_8000, 32'h3F80_8001, 32'h7F7F_FFFF, 32'hFF80_0000,
                32'h7F80_0001, 32'h0000_1234, 32'h8000_0000, 32'hBF80_7FFF};
        vd  = '{16'h3F80, 16'h3F82, 16'h3F81, 16'h7F80, 16'hFF80,
                16'h7FC0, 16'h0000, 16'h8000, 16'hBF80};
        vf  = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01};
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_data = vin[i]; in_last = i[0];
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            wait_n = 0;
            while (!out_valid && wait_n < 5) begin
                @(posedge clk); @(negedge clk); wait_n++;
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== vd[i] || out_flags !== vf[i] || out_last !== i[0]) begin
                errors++;
                $display("FAIL vector_%0d in=%h got v=%b %h/%b/%b want 1 %h/%b/%b",
                         i, vin[i], out_valid, out_data, out_flags, out_last, vd[i], vf[i], i[0]);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] words [8];
        int acc, got, cyc;
        bit started;
        exp_t e;
        for (int i = 0; i < 8; i++) words[i] = rand_word();
        out_ready = 1'b0;
        acc = 0;
        cyc = 0;
        while (acc < 8 && cyc < 12) begin
            in_valid = 1'b1; in_data = words[acc]; in_last = (acc == 7);
            if (!in_ready) break;
            acc++;
            @(posedge clk); @(negedge clk); cyc++;
        end
        checks++; if (acc !== 5) begin errors++; $display("FAIL bp_accepts got %0d want 5", acc); end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL bp_level got %0d want 4", level); end
        checks++; if (out_data !== model(words[0], 1'b0).d) begin errors++; $display("FAIL bp_hold got %h want %h", out_data, model(words[0], 1'b0).d); end
        out_ready = 1'b1;
        got = 0; cyc = 0; started = 0;
        while (got < 8 && cyc < 40) begin
            if (out_valid) begin
                e = model(words[got], got == 7);
                started = 1;
                checks++;
                if (out_data !== e.d || out_flags !== e.f || out_last !== e.l) begin
                    errors++;
                    $display("FAIL bp_word_%0d got %h/%b/%b want %h/%b/%b", got, out_data, out_flags, out_last, e.d, e.f, e.l);
                end
                got++;
            end else if (started) begin
                checks++; errors++;
                $display("FAIL bp_gap at word %0d got out_valid=0 want 1", got);
            end
            if (acc < 8 && in_ready) begin
                in_valid = 1'b1; in_data = words[acc]; in_last = (acc == 7); acc++;
            end else if (acc >= 8) begin
                in_valid = 1'b0;
            end
            @(posedge clk); @(negedge clk); cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (got !== 8) begin errors++; $display("FAIL bp_count got %0d want 8", got); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = rand_word(); in_last = (i == 2);
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_mid_level got %0d want 0", level); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
        out_ready = 1'b1;
        w = 32'h4049_0FDB;
        in_valid = 1'b1; in_data = w; in_last = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_early got out_valid=%b want 0", out_valid); end
        @(posedge clk); @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h4049 || out_flags !== 2'b01 || out_last !== 1'b1 || level !== 3'd1) begin
            errors++;
            $display("FAIL rst_mid_word got v=%b %h/%b/%b lvl=%0d want 1 4049/01/1 lvl=1", out_valid, out_data, out_flags, out_last, level);
        end
        @(posedge clk); @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_alone got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_random();
        exp_t e;
        int cyc;
        q.delete();
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                e = q.pop_front();
                checks++;
                if (out_data !== e.d || out_flags !== e.f || out_last !== e.l) begin
                    errors++;
                    $display("FAIL rand_word got %h/%b/%b want %h/%b/%b", out_data, out_flags, out_last, e.d, e.f, e.l);
                end
            end
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = rand_word();
            in_last  = ($urandom_range(0, 7) == 0);
            if (in_valid && in_ready) q.push_back(model(in_data, in_last));
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while ((q.size() != 0 || out_valid) && cyc < 50) begin
            if (out_valid) begin
                e = q.pop_front();
                checks++;
                if (out_data !== e.d || out_flags !== e.f || out_last !== e.l) begin
                    errors++;
                    $display("FAIL rand_drain got %h/%b/%b want %h/%b/%b", out_data, out_flags, out_last, e.d, e.f, e.l);
                end
            end
            @(posedge clk); @(negedge clk); cyc++;
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_leftover got %0d want 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
